// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// master drives the controls and observes the count; slave is the counter itself.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_out;
  logic             at_max;
  logic             at_min;
  logic             event_pulse;
  logic             overflow;

  // Level-sampled controls: every input is taken at each rising edge with no
  // valid/ready handshake; the outputs are valid in every cycle.
  modport master (
    output enable, up_down, clear, load, load_value,
    input  count_out, at_max, at_min, event_pulse, overflow
  );

  modport slave (
    input  enable, up_down, clear, load, load_value,
    output count_out, at_max, at_min, event_pulse, overflow
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, clamped parallel load, soft clear,
// wrap or saturate at the boundaries, and boundary-event / sticky overflow flags.
module mod_updown_counter #(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned MODULUS     = 256,
  parameter int              SATURATE    = 0,
  parameter longint unsigned RESET_VALUE = 0
) (
  input logic                 clock,
  input logic                 reset,
  mod_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);
  localparam bit               SAT_MODE    = (SATURATE != 0);

  logic [WIDTH-1:0] count_q;
  logic             event_q;
  logic             overflow_q;

  logic [WIDTH-1:0] step_count;
  logic [WIDTH-1:0] load_count;
  logic             at_boundary;

  // The boundary is an explicit compare against MAX_COUNT / zero, so a modulus
  // below 2^WIDTH wraps correctly instead of relying on register rollover.
  always_comb begin
    at_boundary = 1'b0;
    step_count  = count_q;
    load_count  = bus.load_value;
    if (bus.up_down) begin
      at_boundary = (count_q == MAX_COUNT);
    end else begin
      at_boundary = (count_q == '0);
    end
    if (at_boundary) begin
      if (SAT_MODE) begin
        step_count = count_q;
      end else if (bus.up_down) begin
        step_count = '0;
      end else begin
        step_count = MAX_COUNT;
      end
    end else if (bus.up_down) begin
      step_count = count_q + WIDTH'(1);
    end else begin
      step_count = count_q - WIDTH'(1);
    end
    if (bus.load_value > MAX_COUNT) begin
      load_count = MAX_COUNT;
    end
  end

  // Priority: reset > clear > load > step > hold. Load leaves overflow alone.
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      count_q    <= RESET_COUNT;
      event_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.load) begin
      count_q    <= load_count;
      event_q    <= 1'b0;
    end else if (bus.enable) begin
      count_q    <= step_count;
      event_q    <= at_boundary;
      overflow_q <= overflow_q | at_boundary;
    end else begin
      event_q    <= 1'b0;
    end
  end

  assign bus.count_out   = count_q;
  assign bus.at_max      = (count_q == MAX_COUNT);
  assign bus.at_min      = (count_q == '0);
  assign bus.event_pulse = event_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations (wrap 0..9, saturate 0..9,
// 8-bit full range from 250) driven together and scored against a reference model.
module tb_mod_updown_counter;

  typedef struct {
    bit rst;
    bit clr;
    bit ld;
    bit en;
    bit ud;
    int lv;
  } ctrl_t;

  typedef struct {
    int cnt;
    bit pulse;
    bit ovf;
  } model_t;

  logic clock;
  logic reset_a, reset_s, reset_b;

  mod_updown_counter_if #(.WIDTH(4)) if_a ();
  mod_updown_counter_if #(.WIDTH(4)) if_s ();
  mod_updown_counter_if #(.WIDTH(8)) if_b ();

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) dut_a (
    .clock(clock), .reset(reset_a), .bus(if_a));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VALUE(0)) dut_s (
    .clock(clock), .reset(reset_s), .bus(if_s));
  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .RESET_VALUE(250)) dut_b (
    .clock(clock), .reset(reset_b), .bus(if_b));

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_s[$];
  logic [11:0] exp_q_b[$];
  int checks = 0;
  int errors = 0;
  model_t ma, ms, mb;

  function automatic ctrl_t idle();
    ctrl_t c;
    c.rst = 0; c.clr = 0; c.ld = 0; c.en = 0; c.ud = 0; c.lv = 0;
    return c;
  endfunction

  function automatic ctrl_t mk(bit rst, bit clr, bit ld, int lv, bit en, bit ud);
    ctrl_t c;
    c.rst = rst; c.clr = clr; c.ld = ld; c.lv = lv; c.en = en; c.ud = ud;
    return c;
  endfunction

  // Reference: a step is cnt +/- 1 in plain integers; leaving [0, m-1] is a
  // boundary event, resolved by holding (saturate) or taking it modulo m (wrap).
  function automatic model_t model_next(model_t s, ctrl_t c, int m, bit sat, int rv);
    model_t n;
    int stepped;
    bit crossed;
    n = s;
    n.pulse = 0;
    if (c.rst || c.clr) begin
      n.cnt = rv;
      n.ovf = 0;
    end else if (c.ld) begin
      n.cnt = (c.lv < m) ? c.lv : m - 1;
    end else if (c.en) begin
      stepped = s.cnt + (c.ud ? 1 : -1);
      crossed = (stepped < 0) || (stepped >= m);
      n.pulse = crossed;
      n.cnt   = crossed ? (sat ? s.cnt : (stepped + m) % m) : stepped;
      n.ovf   = s.ovf || crossed;
    end
    return n;
  endfunction

  function automatic logic [11:0] pack(model_t s, int m);
    logic [7:0] c8;
    c8 = 8'(s.cnt);
    return {c8, (s.cnt == m - 1), (s.cnt == 0), s.pulse, s.ovf};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_all(input ctrl_t ca, input ctrl_t cs, input ctrl_t cb);
    reset_a = ca.rst; if_a.clear = ca.clr; if_a.load = ca.ld;
    if_a.load_value = 4'(ca.lv); if_a.enable = ca.en; if_a.up_down = ca.ud;
    reset_s = cs.rst; if_s.clear = cs.clr; if_s.load = cs.ld;
    if_s.load_value = 4'(cs.lv); if_s.enable = cs.en; if_s.up_down = cs.ud;
    reset_b = cb.rst; if_b.clear = cb.clr; if_b.load = cb.ld;
    if_b.load_value = 8'(cb.lv); if_b.enable = cb.en; if_b.up_down = cb.ud;
    ma = model_next(ma, ca, 10, 1'b0, 0);
    ms = model_next(ms, cs, 10, 1'b1, 0);
    mb = model_next(mb, cb, 256, 1'b0, 250);
    exp_q_a.push_back(pack(ma, 10));
    exp_q_s.push_back(pack(ms, 10));
    exp_q_b.push_back(pack(mb, 256));
    @(posedge clock);
    #2;
  endtask

  task automatic drive_a(input ctrl_t c);
    drive_all(c, idle(), idle());
  endtask

  task automatic drive_s(input ctrl_t c);
    drive_all(idle(), c, idle());
  endtask

  task automatic drive_b(input ctrl_t c);
    drive_all(idle(), idle(), c);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- monitors ----------------
  always @(posedge clock) begin
    #1;
    if (exp_q_a.size() > 0) begin
      logic [11:0] e, g;
      e = exp_q_a.pop_front();
      g = {4'b0, if_a.count_out, if_a.at_max, if_a.at_min, if_a.event_pulse, if_a.overflow};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_wrap @%0t: got cnt=%0d flags=%b expected cnt=%0d flags=%b",
                 $time, g[11:4], g[3:0], e[11:4], e[3:0]);
      end
    end
    if (exp_q_s.size() > 0) begin
      logic [11:0] e, g;
      e = exp_q_s.pop_front();
      g = {4'b0, if_s.count_out, if_s.at_max, if_s.at_min, if_s.event_pulse, if_s.overflow};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_sat @%0t: got cnt=%0d flags=%b expected cnt=%0d flags=%b",
                 $time, g[11:4], g[3:0], e[11:4], e[3:0]);
      end
    end
    if (exp_q_b.size() > 0) begin
      logic [11:0] e, g;
      e = exp_q_b.pop_front();
      g = {if_b.count_out, if_b.at_max, if_b.at_min, if_b.event_pulse, if_b.overflow};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_full @%0t: got cnt=%0d flags=%b expected cnt=%0d flags=%b",
                 $time, g[11:4], g[3:0], e[11:4], e[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic ctrl_t rand_ctrl(int lv_max);
    ctrl_t c;
    c.rst = ($urandom_range(0, 63) == 0);
    c.clr = ($urandom_range(0, 31) == 0);
    c.ld  = ($urandom_range(0, 7) == 0);
    c.lv  = int'($urandom_range(0, lv_max));
    c.en  = ($urandom_range(0, 3) != 0);
    c.ud  = ($urandom_range(0, 2) != 0);
    return c;
  endfunction

  initial begin
    ma.cnt = 0;   ma.pulse = 0; ma.ovf = 0;
    ms.cnt = 0;   ms.pulse = 0; ms.ovf = 0;
    mb.cnt = 250; mb.pulse = 0; mb.ovf = 0;

    // Reset with enable/up held: reset must win.
    drive_all(mk(1, 0, 0, 0, 1, 1), mk(1, 0, 0, 0, 1, 1), mk(1, 0, 0, 0, 1, 1));
    check("reset_count", int'(if_a.count_out), 0);
    check("reset_at_min", int'(if_a.at_min), 1);
    check("reset_pulse", int'(if_a.event_pulse), 0);
    check("reset_ovf", int'(if_a.overflow), 0);
    check("reset_b_count", int'(if_b.count_out), 250);

    // Count up 12 edges: 1..9, 0 (event), 1, 2.
    for (int i = 1; i <= 12; i++) begin
      drive_a(mk(0, 0, 0, 0, 1, 1));
      check("up_count", int'(if_a.count_out), i % 10);
      check("up_pulse", int'(if_a.event_pulse), (i == 10) ? 1 : 0);
      check("up_ovf", int'(if_a.overflow), (i >= 10) ? 1 : 0);
      check("up_at_max", int'(if_a.at_max), (i == 9) ? 1 : 0);
    end

    // Down from 0 wraps to 9; clear then drops overflow.
    drive_a(mk(0, 1, 0, 0, 0, 0));
    drive_a(mk(0, 0, 0, 0, 1, 0));
    check("down_wrap_count", int'(if_a.count_out), 9);
    check("down_wrap_pulse", int'(if_a.event_pulse), 1);
    drive_a(mk(0, 1, 0, 0, 1, 0));
    check("clear_count", int'(if_a.count_out), 0);
    check("clear_ovf", int'(if_a.overflow), 0);

    // Load beats enable; out-of-range load clamps.
    drive_a(mk(0, 0, 1, 7, 1, 1));
    check("load_count", int'(if_a.count_out), 7);
    drive_a(mk(0, 0, 1, 13, 1, 1));
    check("load_clamp", int'(if_a.count_out), 9);
    check("load_pulse", int'(if_a.event_pulse), 0);
    drive_a(mk(0, 1, 1, 3, 1, 1));
    check("clear_beats_load", int'(if_a.count_out), 0);

    // Saturating counter at both boundaries.
    drive_s(mk(0, 0, 1, 9, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive_s(mk(0, 0, 0, 0, 1, 1));
      check("sat_hi_count", int'(if_s.count_out), 9);
      check("sat_hi_pulse", int'(if_s.event_pulse), 1);
    end
    drive_s(mk(0, 0, 0, 0, 1, 0));
    check("sat_down1", int'(if_s.count_out), 8);
    drive_s(mk(0, 0, 0, 0, 1, 0));
    check("sat_down2", int'(if_s.count_out), 7);
    drive_s(mk(0, 0, 1, 0, 0, 0));
    drive_s(mk(0, 0, 0, 0, 1, 0));
    check("sat_lo_count", int'(if_s.count_out), 0);
    check("sat_lo_pulse", int'(if_s.event_pulse), 1);

    // Full-range counter from 250: 251..255 then 0.
    for (int i = 251; i <= 256; i++) begin
      drive_b(mk(0, 0, 0, 0, 1, 1));
      check("full_count", int'(if_b.count_out), i % 256);
    end
    check("full_wrap_pulse", int'(if_b.event_pulse), 1);

    // Randomised priority mix on all three instances.
    for (int i = 0; i < 10000; i++) begin
      drive_all(rand_ctrl(15), rand_ctrl(15), rand_ctrl(255));
    end

    @(posedge clock);
    #3;
    check("queue_drained", exp_q_a.size() + exp_q_s.size() + exp_q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised up/down counter with programmable modulus, parallel load, soft clear, and wrap or saturate mode. It generalises the existing fixed 4-bit up-counter. It serves as the general-purpose event and timebase counter for the design: prescalers, BCD digits, and bounded occupancy counts. It adds terminal-count status and boundary-event flags so downstream logic does not have to decode the count itself.

## Interface
- WIDTH, 8: count register width in bits; legal range 1..32.
- MODULUS, 256: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0: 0 = wrap at boundaries; 1 = hold at boundaries.
- RESET_VALUE, 0: count after reset or clear; must be < MODULUS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  count step qualifier.
- up_down  in  1  1 = increment, 0 = decrement; sampled only when stepping.
- clear  in  1  synchronous soft clear to RESET_VALUE; also clears `overflow`.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value to load.
- count_out  out  WIDTH  current count, registered.
- at_max  out  1  high when count_out == MODULUS-1.
- at_min  out  1  high when count_out == 0.
- event_pulse  out  1  registered one-cycle pulse on a wrap, or on an attempted step past a boundary in saturate mode.
- overflow  out  1  sticky form of event_pulse.

## Operation
- Priority per rising edge, highest first: reset > clear > load > enable step > hold.
- reset or clear: count_out = RESET_VALUE and event_pulse = 0.
  - overflow is cleared by both reset and clear.
- load: count_out = load_value if load_value < MODULUS, else MODULUS-1 (clamped).
  - load never asserts event_pulse.
  - load leaves overflow unchanged.
- Up step, count < MODULUS-1: count + 1.
- Up step, count == MODULUS-1:
  - SATURATE=0: wrap to 0 and assert event_pulse.
  - SATURATE=1: hold at MODULUS-1 and assert event_pulse.
- Down step, count > 0: count - 1.
- Down step, count == 0:
  - SATURATE=0: wrap to MODULUS-1 and assert event_pulse.
  - SATURATE=1: hold at 0 and assert event_pulse.
- event_pulse is 0 on every edge that does not take a boundary action.
- overflow is set by any event_pulse and stays high until reset or clear.
- Arithmetic: compare against MODULUS-1 explicitly; never rely on natural WIDTH-bit rollover. When MODULUS == 2^WIDTH the results are identical, but the compare path must still be present.
- at_max and at_min decode count_out combinationally.
- No state machine beyond the count register and the two flag registers.

## Timing
- Reset values:
  - count_out = RESET_VALUE.
  - event_pulse = 0.
  - overflow = 0.
  - at_max and at_min follow from RESET_VALUE.
- Latency: any control input sampled at edge N is reflected on count_out, event_pulse, and overflow after edge N. at_max and at_min update in the same cycle as count_out.
- enable held high gives one step per clock; there is no internal prescale.
- Simultaneous events:
  - load with enable: load wins and the step is dropped.
  - clear with load: clear wins.
  - reset with anything: reset wins.
- Reset mid-count forces RESET_VALUE on the next edge regardless of enable. The existing counter lets enable override reset; this block does not.
- up_down may change every cycle; there is no turnaround penalty.

## Test plan
Unless noted, WIDTH=4, MODULUS=10, SATURATE=0, RESET_VALUE=0.
- Reset with enable=1 and up_down=1 held: after the reset edge, count_out=0, at_min=1, event_pulse=0, overflow=0. Releasing reset gives 1 after the next edge.
- Count up 12 edges from 0: 1..9, then 0 on edge 10 with event_pulse=1 for exactly one cycle, overflow=1 and held, at_max=1 while the count is 9. Then 1, 2.
- Down from 0 with one edge: count_out=9 and event_pulse=1. clear on the following edge gives 0 with overflow=0.
- load_value=7 with load=1 and enable=1 on the same edge: count_out=7, no increment. load_value=13: count_out=9 (clamped), event_pulse=0.
- SATURATE=1, at 9, up for 3 edges: count_out stays 9 and event_pulse=1 on each attempted step. Switch to down: 8, 7. Down from 0 holds at 0 with event_pulse=1.
- WIDTH=8, MODULUS=256, RESET_VALUE=250, up: 251..255, then 0 with event_pulse=1. Randomised priority check against a reference model for 10k cycles.
